capture_fifo_v2: RTL and testbench
==================================

Name: capture_fifo_v2

Overview:
Parametrised capture buffer for the logic analyzer. Each decoded protocol byte is tagged with a protocol ID, a free-running timestamp and a timestamp-wrap marker, then queued for readout.
Over the previous capture FIFO it adds:
- correct simultaneous read/write accounting
- write-through when full
- sticky overflow with a saturating drop counter
- almost-full threshold, fill level and synchronous flush
It sits between the UART/SPI/I2C decoders and the host readout logic.

Parameters:
DATA_W, 8, payload width in bits
ID_W, 2, protocol ID width
TS_W, 8, timestamp counter width
DEPTH, 16, entry count; power of two, >= 2
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; 1..DEPTH
DROP_W, 8, width of the saturating dropped-write counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
proto_id  in  ID_W  protocol tag of incoming word (00 UART, 01 SPI, 10 I2C)
data_in  in  DATA_W  payload
wr_en  in  1  write request
rd_en  in  1  read request
flush  in  1  synchronous empty
ovf_clr  in  1  clears overflow and drop_cnt
rd_data  out  ENTRY_W  read entry {proto_id, wrap, timestamp, data}; ENTRY_W = ID_W+1+TS_W+DATA_W
rd_valid  out  1  one-cycle strobe: rd_data updated
empty  out  1  level == 0 (combinational from count)
full  out  1  level == DEPTH
almost_full  out  1  level >= AF_THRESH
level  out  $clog2(DEPTH+1)  current occupancy
ovf_pulse  out  1  one-cycle strobe per dropped write
overflow  out  1  sticky overflow flag
drop_cnt  out  DROP_W  dropped writes since last clear, saturating

Behaviour:
- Reset (rst high, async): pointers, count, timestamp, wrap_pending, rd_data, rd_valid, ovf_pulse, overflow and drop_cnt are all 0. Memory contents are don't-care.
- Timestamp: increments by 1 every cycle and wraps modulo 2^TS_W.
  - wrap_pending sets on the cycle the timestamp rolls from all-ones to 0.
- Entry capture: an accepted write stores {proto_id, wrap_pending, timestamp (pre-increment value this cycle), data_in}.
  - wrap_pending then clears, unless a roll occurs the same cycle, in which case it stays set.
- rd_fire = rd_en && !empty && !flush.
- wr_fire = wr_en && !flush && (!full || rd_fire). A write to a full FIFO is accepted when a read fires the same cycle.
- Count update: wr_fire only +1; rd_fire only -1; both unchanged; neither unchanged.
- Pointers advance on their fire and wrap modulo DEPTH. A same-cycle read at full returns the oldest entry, never the one being written.
- Read latency 1:
  - rd_data loads mem[rd_ptr] on rd_fire.
  - rd_valid is high the following cycle only.
  - rd_data holds its value otherwise.
  - rd_en on empty: ignored, no rd_valid, no error.
- Drop = wr_en && !flush && full && !rd_fire. A drop:
  - pulses ovf_pulse for 1 cycle
  - sets overflow
  - increments drop_cnt, saturating at all-ones
- ovf_clr: next cycle overflow = 0 and drop_cnt = 0. If a drop coincides with ovf_clr, overflow = 1 and drop_cnt = 1 (set wins).
- flush: next cycle pointers and count = 0.
  - Any same-cycle wr_en/rd_en is ignored.
  - No rd_valid and no drop are generated.
  - Timestamp, wrap_pending, overflow and drop_cnt are unaffected.
- Status outputs (empty, full, almost_full, level) are combinational from count.

Decomposition:
- Shared package capture_pkg holds:
  - PROTO_UART = 2'b00, PROTO_SPI = 2'b01, PROTO_I2C = 2'b10
  - entry field offset/width localparams derived from the parameters
  - function computing ENTRY_W
- Sub-module cap_timestamp: TS_W counter with a roll strobe output. Reused by the decoders for timing.
- Memory array, pointers and status logic stay in capture_fifo_v2.

Test Plan:
- Reset, write 3 words (UART 0x41, SPI 0x5A, I2C 0xC3) on cycles 2,3,4, then read 3 -> entries in order, timestamps 2,3,4, wrap=0, rd_valid 1 cycle after each rd_en, level 3 -> 0.
- Fill 16 entries -> full=1, almost_full asserted at level 12; 3 more writes -> 3 ovf_pulse strobes, overflow=1, drop_cnt=3, level stays 16; ovf_clr -> overflow=0, drop_cnt=0.
- At full, wr_en and rd_en same cycle -> oldest entry returned, new entry accepted, level stays 16, no ovf_pulse.
- Hold writes off for 256 cycles, then write 0x77 -> entry wrap=1; next write -> wrap=0.
- Level 5, assert flush together with wr_en and rd_en -> next cycle level=0, empty=1, no rd_valid, overflow/drop_cnt unchanged; rd_en on empty -> no rd_valid.
- Force 300 drops -> drop_cnt saturates at 255; assert rst mid-burst -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/capture_fifo_v2_pkg.sv
// Shared definitions for the logic-analyzer capture path: protocol tags,
// entry layout helpers and default field geometry.
package capture_pkg;

   // Protocol tags carried in the top bits of every captured entry
   localparam logic [1:0] PROTO_UART = 2'b00;
   localparam logic [1:0] PROTO_SPI  = 2'b01;
   localparam logic [1:0] PROTO_I2C  = 2'b10;

   // Entry layout, LSB first: data | timestamp | wrap | proto_id
   function automatic int entry_w(input int id_w, input int ts_w, input int data_w);
      return id_w + 1 + ts_w + data_w;
   endfunction

   function automatic int ts_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int wrap_bit(input int data_w, input int ts_w);
      return data_w + ts_w;
   endfunction

   function automatic int id_lsb(input int data_w, input int ts_w);
      return data_w + ts_w + 1;
   endfunction

   // Geometry for the default build, handy for decoders and readout software models
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_ID_W     = 2;
   localparam int DEF_TS_W     = 8;
   localparam int DEF_ENTRY_W  = entry_w(DEF_ID_W, DEF_TS_W, DEF_DATA_W);
   localparam int DEF_TS_LSB   = ts_lsb(DEF_DATA_W);
   localparam int DEF_WRAP_BIT = wrap_bit(DEF_DATA_W, DEF_TS_W);
   localparam int DEF_ID_LSB   = id_lsb(DEF_DATA_W, DEF_TS_W);

endpackage

// File: rtl/capture_fifo_v2_if.sv
// Decoder/readout side of the capture FIFO. The slave modport is the FIFO,
// the master modport is whoever feeds bytes in and drains entries out.
interface capture_fifo_v2_if
   import capture_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ID_W   = 2,
   parameter int TS_W   = 8,
   parameter int DEPTH  = 16,
   parameter int DROP_W = 8
) ();

   localparam int ENTRY_W = entry_w(ID_W, TS_W, DATA_W);
   localparam int LVL_W   = $clog2(DEPTH + 1);

   // Write side
   logic [ID_W-1:0]    proto_id;
   logic [DATA_W-1:0]  data_in;
   logic               wr_en;
   // Read side and control
   logic               rd_en;
   logic               flush;
   logic               ovf_clr;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;
   // Status
   logic               empty;
   logic               full;
   logic               almost_full;
   logic [LVL_W-1:0]   level;
   logic               ovf_pulse;
   logic               overflow;
   logic [DROP_W-1:0]  drop_cnt;

   modport slave (
      input  proto_id, data_in, wr_en, rd_en, flush, ovf_clr,
      output rd_data, rd_valid, empty, full, almost_full, level,
             ovf_pulse, overflow, drop_cnt
   );

   modport master (
      output proto_id, data_in, wr_en, rd_en, flush, ovf_clr,
      input  rd_data, rd_valid, empty, full, almost_full, level,
             ovf_pulse, overflow, drop_cnt
   );

endinterface

// File: rtl/capture_fifo_v2_ts.sv
// Free-running timestamp counter. roll_o is high during the cycle whose
// clock edge takes the count from all-ones back to zero.
module cap_timestamp #(
   parameter int TS_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   output logic [TS_W-1:0] ts_o,
   output logic            roll_o
);

   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] ts_d;

   assign ts_d   = ts_q + TS_W'(1);
   assign roll_o = &ts_q;
   assign ts_o   = ts_q;

   // Count every cycle, wrapping naturally modulo 2^TS_W
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (rst) ts_q <= '0;
      else     ts_q <= ts_d;
   end

endmodule

// File: rtl/capture_fifo_v2.sv
// Capture buffer: tags each decoded byte with protocol, timestamp and wrap
// marker, queues it, and tracks occupancy and dropped writes.
module capture_fifo_v2
   import capture_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ID_W      = 2,
   parameter int TS_W      = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12,
   parameter int DROP_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   capture_fifo_v2_if.slave  bus
);

   localparam int ENTRY_W  = entry_w(ID_W, TS_W, DATA_W);
   localparam int TS_LSB   = ts_lsb(DATA_W);
   localparam int WRAP_POS = wrap_bit(DATA_W, TS_W);
   localparam int ID_LSB   = id_lsb(DATA_W, TS_W);
   localparam int PTR_W    = $clog2(DEPTH);
   localparam int LVL_W    = $clog2(DEPTH + 1);

   // Storage and state
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [LVL_W-1:0]   count_q,    count_d;
   logic               wrap_q,     wrap_d;
   logic [ENTRY_W-1:0] rd_data_q,  rd_data_d;
   logic               rd_valid_q;
   logic               ovf_pulse_q;
   logic               overflow_q, overflow_d;
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

   // Timestamp source
   logic [TS_W-1:0]    ts;
   logic               ts_roll;

   // Handshake decode
   logic               empty;
   logic               full;
   logic               rd_fire;
   logic               wr_fire;
   logic               drop;
   logic [ENTRY_W-1:0] wr_entry;

   cap_timestamp #(.TS_W(TS_W)) u_ts (
      .clk    (clk),
      .rst    (rst),
      .ts_o   (ts),
      .roll_o (ts_roll)
   );

   // Status straight from the occupancy count
   assign empty = (count_q == '0);
   assign full  = (count_q == LVL_W'(DEPTH));

   // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it
   assign rd_fire = bus.rd_en && !empty && !bus.flush;
   assign wr_fire = bus.wr_en && !bus.flush && (!full || rd_fire);
   assign drop    = bus.wr_en && !bus.flush && full && !rd_fire;

   // Assemble the entry being written this cycle
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      wr_entry                        = '0;
      wr_entry[0 +: DATA_W]           = bus.data_in;
      wr_entry[TS_LSB +: TS_W]        = ts;
      wr_entry[WRAP_POS]              = wrap_q;
      wr_entry[ID_LSB +: ID_W]        = bus.proto_id;
   end

   // Next-state for pointers, count, wrap marker, read data and drop tracking
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
         endcase
      end

      // Memory read happens before this edge's write, so a read at full sees the oldest entry
      if (rd_fire) rd_data_d = mem[rd_ptr_q];

      // A roll in the same cycle as a write keeps the marker for the next entry
      if (ts_roll)      wrap_d = 1'b1;
      else if (wr_fire) wrap_d = 1'b0;
      else              wrap_d = wrap_q;

      // Clear first, then let a coincident drop override it
      if (bus.ovf_clr) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (bus.ovf_clr)       drop_cnt_d = DROP_W'(1);
         else if (&drop_cnt_q)  drop_cnt_d = drop_cnt_q;
         else                   drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately left out of reset; contents are only read after being written.
      if (wr_fire) mem[wr_ptr_q] <= wr_entry;
   end

   // Queue bookkeeping and wrap marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wrap_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wrap_q   <= wrap_d;
      end
   end

   // Registered read port with a one-cycle valid strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_fire;
      end
   end

   // Overflow reporting: strobe, sticky flag and saturating counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_pulse_q <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         ovf_pulse_q <= drop;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.empty       = empty;
   assign bus.full        = full;
   assign bus.almost_full = (count_q >= LVL_W'(AF_THRESH));
   assign bus.level       = count_q;
   assign bus.ovf_pulse   = ovf_pulse_q;
   assign bus.overflow    = overflow_q;
   assign bus.drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_capture_fifo_v2.sv
// Directed bench for capture_fifo_v2: ordering, tagging, full/drop handling,
// wrap marker, flush and asynchronous reset.
module tb_capture_fifo_v2;
   import capture_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   capture_fifo_v2_if #(.DATA_W(8), .ID_W(2), .TS_W(8), .DEPTH(16), .DROP_W(8)) bus ();

   capture_fifo_v2 #(
      .DATA_W(8), .ID_W(2), .TS_W(8), .DEPTH(16), .AF_THRESH(12), .DROP_W(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference cycle counter: value the DUT timestamp should hold right now
   logic [7:0] tb_ts;
   always @(posedge clk or posedge rst) begin
      if (rst) tb_ts <= 8'd0;
      else     tb_ts <= tb_ts + 8'd1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [18:0] ent(input logic [1:0] id, input logic w,
                                       input logic [7:0] t, input logic [7:0] d);
      return {id, w, t, d};
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write n entries tagged SPI with payload 0..n-1
   task automatic fill(input int n);
      bus.wr_en    = 1'b1;
      bus.proto_id = PROTO_SPI;
      for (int i = 0; i < n; i++) begin
         bus.data_in = 8'(i);
         tick();
      end
      bus.wr_en = 1'b0;
   endtask

   logic [7:0] exp_ts1, exp_ts2;

   initial begin
      bus.proto_id = '0;
      bus.data_in  = '0;
      bus.wr_en    = 1'b0;
      bus.rd_en    = 1'b0;
      bus.flush    = 1'b0;
      bus.ovf_clr  = 1'b0;

      // Reset state
      tick();
      check("rst_level",    64'(bus.level),    64'd0);
      check("rst_empty",    64'(bus.empty),    64'd1);
      check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check("rst_overflow", 64'(bus.overflow), 64'd0);
      check("rst_drop_cnt", 64'(bus.drop_cnt), 64'd0);
      rst = 1'b0;

      // Three tagged writes on cycles 2,3,4 then three reads
      tick();
      tick();
      bus.wr_en = 1'b1;
      bus.proto_id = PROTO_UART; bus.data_in = 8'h41; tick();
      bus.proto_id = PROTO_SPI;  bus.data_in = 8'h5A; tick();
      bus.proto_id = PROTO_I2C;  bus.data_in = 8'hC3; tick();
      bus.wr_en = 1'b0;
      check("t1_level3", 64'(bus.level), 64'd3);
      bus.rd_en = 1'b1;
      tick();
      check("t1_valid0", 64'(bus.rd_valid), 64'd1);
      check("t1_data0",  64'(bus.rd_data),  64'(ent(PROTO_UART, 1'b0, 8'd2, 8'h41)));
      tick();
      check("t1_data1",  64'(bus.rd_data),  64'(ent(PROTO_SPI,  1'b0, 8'd3, 8'h5A)));
      tick();
      check("t1_data2",  64'(bus.rd_data),  64'(ent(PROTO_I2C,  1'b0, 8'd4, 8'hC3)));
      check("t1_level0", 64'(bus.level),    64'd0);
      bus.rd_en = 1'b0;
      tick();
      check("t1_valid_drop", 64'(bus.rd_valid), 64'd0);
      check("t1_empty",      64'(bus.empty),    64'd1);
      check("t1_hold",       64'(bus.rd_data),  64'(ent(PROTO_I2C, 1'b0, 8'd4, 8'hC3)));

      // Fill to full, watch almost_full, then three dropped writes
      bus.wr_en    = 1'b1;
      bus.proto_id = PROTO_SPI;
      for (int i = 0; i < 16; i++) begin
         bus.data_in = 8'(i);
         tick();
         if (i == 10) check("t2_af_l11", 64'(bus.almost_full), 64'd0);
         if (i == 11) check("t2_af_l12", 64'(bus.almost_full), 64'd1);
      end
      check("t2_full",    64'(bus.full),  64'd1);
      check("t2_level16", 64'(bus.level), 64'd16);
      for (int k = 0; k < 3; k++) begin
         bus.data_in = 8'hD0 + 8'(k);
         tick();
         check("t2_ovf_pulse", 64'(bus.ovf_pulse), 64'd1);
         check("t2_level_hold", 64'(bus.level),   64'd16);
      end
      bus.wr_en = 1'b0;
      tick();
      check("t2_pulse_end", 64'(bus.ovf_pulse), 64'd0);
      check("t2_overflow",  64'(bus.overflow),  64'd1);
      check("t2_drop3",     64'(bus.drop_cnt),  64'd3);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("t2_clr_ovf",  64'(bus.overflow), 64'd0);
      check("t2_clr_drop", 64'(bus.drop_cnt), 64'd0);

      // Simultaneous read and write at full
      bus.wr_en = 1'b1; bus.data_in = 8'hEE; bus.rd_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
      check("t3_valid",   64'(bus.rd_valid),     64'd1);
      check("t3_oldest",  64'(bus.rd_data[7:0]), 64'h00);
      check("t3_level",   64'(bus.level),        64'd16);
      check("t3_no_ovf",  64'(bus.ovf_pulse),    64'd0);
      for (int k = 0; k < 16; k++) begin
         tick();
         check("t3_drain", 64'(bus.rd_data[7:0]), (k < 15) ? 64'(k + 1) : 64'hEE);
      end
      bus.rd_en = 1'b0;
      tick();
      check("t3_empty", 64'(bus.empty), 64'd1);

      // Long idle forces a timestamp roll; first write carries the wrap marker
      repeat (256) tick();
      bus.wr_en = 1'b1; bus.proto_id = PROTO_I2C;
      exp_ts1 = tb_ts; bus.data_in = 8'h77; tick();
      exp_ts2 = tb_ts; bus.data_in = 8'h78; tick();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b1;
      tick();
      check("t4_wrap1", 64'(bus.rd_data), 64'(ent(PROTO_I2C, 1'b1, exp_ts1, 8'h77)));
      tick();
      check("t4_wrap0", 64'(bus.rd_data),
            64'(ent(PROTO_I2C, (exp_ts1 == 8'hFF), exp_ts2, 8'h78)));
      bus.rd_en = 1'b0;
      tick();

      // Flush: leaves overflow history intact and suppresses same-cycle traffic
      fill(16);
      bus.wr_en = 1'b1; bus.data_in = 8'hAA;
      tick();
      bus.wr_en = 1'b0;
      check("t5_drop1", 64'(bus.drop_cnt), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("t5_flush_full", 64'(bus.level), 64'd0);
      fill(5);
      check("t5_level5", 64'(bus.level), 64'd5);
      bus.flush = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
      tick();
      bus.flush = 1'b0; bus.wr_en = 1'b0;
      check("t5_level0",  64'(bus.level),     64'd0);
      check("t5_empty",   64'(bus.empty),     64'd1);
      check("t5_novalid", 64'(bus.rd_valid),  64'd0);
      check("t5_nopulse", 64'(bus.ovf_pulse), 64'd0);
      check("t5_ovf_kep", 64'(bus.overflow),  64'd1);
      check("t5_drp_kep", 64'(bus.drop_cnt),  64'd1);
      tick();
      bus.rd_en = 1'b0;
      check("t5_rd_empty", 64'(bus.rd_valid), 64'd0);
      check("t5_still0",   64'(bus.level),    64'd0);

      // Clear coinciding with a drop: set wins
      fill(16);
      bus.wr_en = 1'b1; bus.ovf_clr = 1'b1;
      tick();
      bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
      check("t6_clr_ovf",  64'(bus.overflow), 64'd1);
      check("t6_clr_drop", 64'(bus.drop_cnt), 64'd1);

      // Saturating drop counter, then asynchronous reset mid-burst
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("t7_cleared", 64'(bus.drop_cnt), 64'd0);
      bus.wr_en = 1'b1;
      repeat (255) tick();
      check("t7_drop255", 64'(bus.drop_cnt), 64'd255);
      repeat (45) tick();
      check("t7_sat",      64'(bus.drop_cnt),  64'd255);
      check("t7_pulse_on", 64'(bus.ovf_pulse), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t7_rst_level", 64'(bus.level),       64'd0);
      check("t7_rst_empty", 64'(bus.empty),       64'd1);
      check("t7_rst_full",  64'(bus.full),        64'd0);
      check("t7_rst_af",    64'(bus.almost_full), 64'd0);
      check("t7_rst_ovf",   64'(bus.overflow),    64'd0);
      check("t7_rst_drop",  64'(bus.drop_cnt),    64'd0);
      check("t7_rst_pulse", 64'(bus.ovf_pulse),   64'd0);
      check("t7_rst_data",  64'(bus.rd_data),     64'd0);
      check("t7_rst_valid", 64'(bus.rd_valid),    64'd0);
      bus.wr_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
